// File: rtl/morse_pkg.sv
// Shared types and unit-count constants for the Morse playback path.
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      SYM_GAP,
      CHAR_GAP,
      WORD_GAP
   } state_t;

   localparam logic [2:0] DOT_UNITS      = 3'd1;
   localparam logic [2:0] DASH_UNITS     = 3'd3;
   localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
   localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
   localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
   localparam logic [2:0] MAX_SYM        = 3'd5;

   function automatic logic [2:0] mark_units(input logic dash);
      return dash ? DASH_UNITS : DOT_UNITS;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse time base: clk-cycle counter wrapping every UNIT_CYCLES, plus a units
// counter (0..6) that advances on each wrap. Both clear while i_clear is high.
module morse_unit_timer #(
   parameter int unsigned UNIT_CYCLES = 12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic [2:0] i_units,
   output logic       o_units_reached
);

   localparam int unsigned   CW   = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_units;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_units <= '0;
      end else if (i_clear) begin
         r_cnt   <= '0;
         r_units <= '0;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_units <= (r_units == 3'd6) ? 3'd0 : r_units + 3'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // High in the final clk cycle of the i_units-th unit.
   assign o_units_reached = w_wrap && (r_units == (i_units - 3'd1));

endmodule

// File: rtl/morse_player.sv
// Plays one accepted character (dot/dash pattern + length) as timed Morse on key_out.
// Optional audio tone on tone_out is built only when MORSE_TONE_EN is defined.
module morse_player
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES      = 12000000,
   parameter int unsigned TONE_HALF_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [4:0] sym_seq,
   input  logic [2:0] sym_len,
   input  logic       abort,
   output logic       key_out,
   output logic       busy,
   output logic       char_done,
   output logic       len_err,
   output logic       tone_out
);

   if (UNIT_CYCLES < 2 || TONE_HALF_CYCLES < 1) begin : g_bad_params
      $error("morse_player: UNIT_CYCLES must be >= 2 and TONE_HALF_CYCLES >= 1");
   end

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_seq;
   logic [2:0] r_len;
   logic [2:0] r_idx;
   logic [2:0] w_units;
   logic       w_accept;
   logic       w_clear;
   logic       w_reached;
   logic       w_last_sym;
   logic       r_key;
   logic       r_len_err;

   assign w_accept   = char_valid && (r_state == IDLE) && !abort;
   assign w_last_sym = (r_idx == (r_len - 3'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (sym_len == 3'd0)         w_next = WORD_GAP;
               else if (sym_len <= MAX_SYM) w_next = MARK;
            end
         end
         MARK: begin
            if (w_reached) w_next = w_last_sym ? CHAR_GAP : SYM_GAP;
         end
         SYM_GAP: begin
            if (w_reached) w_next = MARK;
         end
         CHAR_GAP, WORD_GAP: begin
            if (w_reached) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (abort) w_next = IDLE;
   end

   always_comb begin
      char_ready = (r_state == IDLE);
      busy       = (r_state != IDLE);
      char_done  = !abort && w_reached && ((r_state == CHAR_GAP) || (r_state == WORD_GAP));
   end

   // Timer restarts on every state entry and is held clear while idle.
   assign w_clear = (w_next != r_state) || (r_state == IDLE);

   always_comb begin
      w_units = SYM_GAP_UNITS;
      case (r_state)
         MARK:     w_units = mark_units(r_seq[r_idx]);
         SYM_GAP:  w_units = SYM_GAP_UNITS;
         CHAR_GAP: w_units = CHAR_GAP_UNITS;
         WORD_GAP: w_units = WORD_GAP_UNITS;
         default:  w_units = SYM_GAP_UNITS;
      endcase
   end

   morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clear        (w_clear),
      .i_units        (w_units),
      .o_units_reached(w_reached)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq     <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_key     <= 1'b0;
         r_len_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_seq <= sym_seq;
            r_len <= sym_len;
            r_idx <= '0;
         end else if ((r_state == MARK) && w_reached && !abort) begin
            r_idx <= r_idx + 3'd1;
         end
         r_key     <= (w_next == MARK);
         r_len_err <= w_accept && (sym_len > MAX_SYM);
      end
   end

   assign key_out = r_key;
   assign len_err = r_len_err;

`ifdef MORSE_TONE_EN
   localparam int unsigned TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

   logic [TW-1:0] r_tone_cnt;
   logic          r_tone;

   // Cleared from the next-key value so tone_out is never high while key_out is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else if ((w_next != MARK) || !r_key) begin
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else if (r_tone_cnt == TW'(TONE_HALF_CYCLES - 1)) begin
         r_tone_cnt <= '0;
         r_tone     <= ~r_tone;
      end else begin
         r_tone_cnt <= r_tone_cnt + 1'b1;
      end
   end

   assign tone_out = r_tone;
`else
   assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player: table of characters, abort/reset corner cases,
// and random characters compared cycle by cycle against a timing model.
module tb_morse_player;

   localparam int unsigned U  = 4;
   localparam int unsigned TH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic [4:0] sym_seq = '0;
   logic [2:0] sym_len = '0;
   logic       abort = 1'b0;
   logic       key_out;
   logic       busy;
   logic       char_done;
   logic       len_err;
   logic       tone_out;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bit q_key[$];
   bit q_tone[$];

   morse_player #(
      .UNIT_CYCLES     (U),
      .TONE_HALF_CYCLES(TH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .sym_seq   (sym_seq),
      .sym_len   (sym_len),
      .abort     (abort),
      .key_out   (key_out),
      .busy      (busy),
      .char_done (char_done),
      .len_err   (len_err),
      .tone_out  (tone_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  seq;
      logic [2:0]  len;
      int unsigned exp_cycles;
      int unsigned exp_high;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // {key_out, char_done, char_ready, len_err, tone_out}
   function automatic logic [4:0] outs();
      return {key_out, char_done, char_ready, len_err, tone_out};
   endfunction

   // Model: expected key/tone per cycle after accept, built from Morse timing rules.
   function automatic void build_trace(input logic [4:0] seq, input logic [2:0] len);
      int unsigned n;
      q_key.delete();
      q_tone.delete();
      if (len == 3'd0) begin
         for (int unsigned m = 0; m < 7 * U; m++) begin q_key.push_back(1'b0); q_tone.push_back(1'b0); end
      end else if (len <= 3'd5) begin
         for (int i = 0; i < int'(len); i++) begin
            n = seq[i] ? 3 * U : U;
            for (int unsigned m = 0; m < n; m++) begin
               q_key.push_back(1'b1);
`ifdef MORSE_TONE_EN
               q_tone.push_back(bit'((m / TH) % 2));
`else
               q_tone.push_back(1'b0);
`endif
            end
            if (i != int'(len) - 1)
               for (int unsigned m = 0; m < U; m++) begin q_key.push_back(1'b0); q_tone.push_back(1'b0); end
         end
         for (int unsigned m = 0; m < 3 * U; m++) begin q_key.push_back(1'b0); q_tone.push_back(1'b0); end
      end
   endfunction

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle", 32'(outs()), 32'(5'b00100));
      end
   endtask

   task automatic offer(input logic [4:0] seq, input logic [2:0] len, input logic ab);
      @(negedge clk);
      char_valid = 1'b1;
      sym_seq    = seq;
      sym_len    = len;
      abort      = ab;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      abort      = 1'b0;
      sym_seq    = 5'($urandom);
      sym_len    = 3'($urandom);
   endtask

   task automatic send(input logic [4:0] seq, input logic [2:0] len,
                       output int unsigned high_cnt, output int unsigned done_at);
      logic [4:0] exp;
      build_trace(seq, len);
      high_cnt = 0;
      done_at  = 0;
      @(negedge clk);
      check("pre_accept", 32'(outs()), 32'(5'b00100));
      char_valid = 1'b1;
      sym_seq    = seq;
      sym_len    = len;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      sym_seq    = 5'($urandom);
      sym_len    = 3'($urandom);
      if (len > 3'd5) begin
         @(negedge clk);
         check("len_err_cycle", 32'(outs()), 32'(5'b00110));
      end else begin
         for (int j = 0; j < q_key.size(); j++) begin
            @(negedge clk);
            exp = {q_key[j], (j == q_key.size() - 1), 1'b0, 1'b0, q_tone[j]};
            check("trace", 32'(outs()), 32'(exp));
            if (key_out === 1'b1) high_cnt++;
            if (char_done === 1'b1 && done_at == 0) done_at = 32'(j + 1);
         end
      end
   endtask

   vec_t        tbl[8];
   int unsigned h, d;

   initial begin
      tbl[0] = '{5'b00000, 3'd1, 16, 4};    // E
      tbl[1] = '{5'b00010, 3'd2, 32, 16};   // A
      tbl[2] = '{5'b00001, 3'd1, 24, 12};   // T
      tbl[3] = '{5'b00000, 3'd0, 28, 0};    // word space
      tbl[4] = '{5'b00000, 3'd6, 0, 0};     // invalid
      tbl[5] = '{5'b11111, 3'd5, 88, 60};   // 0
      tbl[6] = '{5'b00000, 3'd5, 48, 20};   // 5
      tbl[7] = '{5'b01011, 3'd4, 64, 40};   // Q

      #12;
      check("reset_outs", 32'(outs()), 32'(5'b00100));
      check("reset_busy", 32'(busy), 32'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Table: characters sent back to back
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].seq, tbl[i].len, h, d);
         if (tbl[i].len <= 3'd5) begin
            check("tbl_high_cycles", 32'(h), 32'(tbl[i].exp_high));
            check("tbl_done_cycle", 32'(d), 32'(tbl[i].exp_cycles));
         end
      end
      send(5'b00000, 3'd7, h, d);
      idle(3);

      // Abort three cycles into the dash of T
      offer(5'b00001, 3'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_mark_key", 32'(key_out), 32'(1'b1));
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_next", 32'({key_out, char_done, char_ready, busy}), 32'(4'b0010));
      idle(15);

      // Abort coincident with an offered character: character dropped
      offer(5'b00001, 3'd1, 1'b1);
      @(negedge clk);
      check("abort_accept", 32'(outs()), 32'(5'b00100));
      idle(6);
      offer(5'b00000, 3'd6, 1'b1);
      @(negedge clk);
      check("abort_len_err", 32'(outs()), 32'(5'b00100));

      // Reset mid-mark
      offer(5'b00001, 3'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_key", 32'(key_out), 32'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", 32'({key_out, char_ready, busy, char_done, len_err, tone_out}), 32'(6'b010000));
      @(negedge clk);
      rst_n = 1'b1;
      idle(16);
      send(5'b00000, 3'd1, h, d);
      check("post_rst_done", 32'(d), 32'd16);

      // Random characters with random idle gaps
      for (int i = 0; i < 40; i++) begin
         logic [4:0] rs;
         logic [2:0] rl;
         rs = 5'($urandom);
         rl = 3'($urandom_range(0, 7));
         send(rs, rl, h, d);
         if (rl <= 3'd5) check("rand_done_cycle", 32'(d), 32'(q_key.size()));
         idle($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/morse_player.md
Name: morse_player

Overview:
- Transmit-side counterpart of the button-driven Morse entry path.
- Takes one character at a time as a symbol pattern (dot/dash bits plus length) over a valid/ready handshake.
- Plays the character back as standard-timed Morse on a single key line that drives an LED or buzzer pin.
- Sits between the stored character sequence (encoder output / replay logic) and a board output pin.

Parameters:
- UNIT_CYCLES, 12000000, clk cycles per Morse time unit (120 ms at 100 MHz, about 10 WPM); must be >= 2.
- TONE_HALF_CYCLES, 50000, clk cycles per half-period of the audio tone (1 kHz at 100 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  character offered.
- char_ready  out  1  block can accept a character.
- sym_seq  in  5  symbols, LSB first; 1 = dash, 0 = dot.
- sym_len  in  3  symbol count, 1..5; 0 = word space; 6..7 invalid.
- abort  in  1  synchronous cancel of current playback.
- key_out  out  1  Morse key line, 1 = mark.
- busy  out  1  playback in progress (~char_ready).
- char_done  out  1  one-cycle pulse when a character or space finishes.
- len_err  out  1  one-cycle pulse when an invalid length is accepted.
- tone_out  out  1  gated square-wave audio.

Behaviour:
- Reset (async, rst_n low): state IDLE, all counters 0. Outputs: key_out=0, char_ready=1, busy=0, char_done=0, len_err=0, tone_out=0. Reset asserted mid-character drops key_out immediately and discards the character.
- char_ready=1 only in IDLE. A character is accepted at a clk edge with char_valid & char_ready. sym_seq and sym_len are latched at that edge; later input changes are ignored.
- States and transitions:
  - IDLE.
  - MARK: key_out=1. Lasts 1*UNIT_CYCLES cycles for a dot, 3*UNIT_CYCLES for a dash.
  - SYM_GAP: key_out=0 for 1*UNIT_CYCLES. Entered after any symbol except the last.
  - CHAR_GAP: key_out=0 for 3*UNIT_CYCLES. Entered directly after the last symbol; it is not added to SYM_GAP.
  - WORD_GAP: key_out=0 for 7*UNIT_CYCLES. Entered on accept with sym_len=0.
- Accept at edge k: the new state is effective from cycle k+1. key_out is registered and rises in cycle k+1.
- The symbol index increments at the end of each MARK. MARK is left for CHAR_GAP when index == sym_len-1.
- char_done pulses in the last cycle of CHAR_GAP or WORD_GAP. IDLE (char_ready=1) follows in the next cycle. Back-to-back characters get no extra gap cycles.
- sym_len 6 or 7: the character is accepted, len_err pulses in cycle k+1, state stays IDLE, key_out stays 0, no char_done.
- abort (sampled each edge, priority over all transitions): next cycle IDLE, key_out=0, no char_done.
  - abort with char_valid & char_ready in the same cycle: abort wins and the character is dropped.
- Unit counter: counts 0..UNIT_CYCLES-1 and wraps. A units counter (0..6) advances on each wrap. Both clear on every state entry.
- Counter width is $clog2(UNIT_CYCLES); the units counter is 3 bits.

Optional Feature:
- Macro: MORSE_TONE_EN.
- Defined: a free-running half-period counter toggles tone_out every TONE_HALF_CYCLES while key_out=1. tone_out is forced 0 and the counter cleared while key_out=0.
- Undefined: tone_out is tied to 0 and no tone counter is synthesized.

Decomposition:
- Shared package morse_pkg holds:
  - state enum (IDLE, MARK, SYM_GAP, CHAR_GAP, WORD_GAP);
  - unit-count constants DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7;
  - MAX_SYM=5.
- One natural sub-module, morse_unit_timer: the unit-tick counter plus units counter, with a clear input and a units_reached output.

Test Plan (UNIT_CYCLES=4, TONE_HALF_CYCLES=2):
- E (sym_seq=0, sym_len=1) accepted at edge k -> key_out=1 for cycles k+1..k+4, 0 for k+5..k+16; char_done at k+16; char_ready=1 at k+17.
- A (sym_seq=5'b00010, sym_len=2) -> key_out: 4 high, 4 low, 12 high, 12 low; exactly one char_done pulse.
- Space (sym_len=0) -> key_out low 28 cycles; char_done at cycle 28 after accept; ready the next cycle.
- sym_len=6 -> len_err one-cycle pulse; char_ready stays 1; key_out never rises; no char_done.
- abort 3 cycles into the dash of T (sym_seq=1, sym_len=1) -> key_out=0 and char_ready=1 the next cycle; no char_done. Repeat using rst_n low mid-mark -> outputs at reset values immediately.
- With MORSE_TONE_EN, play E -> tone_out toggles every 2 cycles during the 4-cycle mark and is 0 elsewhere. Without the macro -> tone_out constant 0.
